// File: rtl/fnd_scan_periph.sv
// fnd_scan_periph: APB-programmable 4-digit, 7-segment display scanner.
// Registers: FCR (enable), FDR (four hex digits), FDP (decimal points),
// FPR (scan prescale). Each access is answered with one wait state.
// The display is multiplexed one digit at a time, paced by a prescaler.
// Optional build macro FND_LEADING_ZERO_BLANK_EN blanks leading zero digits
// above the most-significant nonzero nibble, unless that digit's decimal
// point is lit. Digit 0 is never blanked.
//
// APB handshake FSM
//   state    | meaning
//   APB_IDLE | waiting for PSEL&&PENABLE; commits the access and raises PREADY
//   APB_ACK  | PREADY high for this one cycle; any held select is ignored
module fnd_scan_periph (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic [3:0]  PADDR,
  input  logic [31:0] PWDATA,
  input  logic        PWRITE,
  input  logic        PENABLE,
  input  logic        PSEL,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic [3:0]  fndcomm,
  output logic [7:0]  fndfont
);

  typedef enum logic {
    APB_IDLE = 1'b0,
    APB_ACK  = 1'b1
  } apb_state_t;

  localparam logic [1:0]  SEL_FCR   = 2'd0;
  localparam logic [1:0]  SEL_FDR   = 2'd1;
  localparam logic [1:0]  SEL_FDP   = 2'd2;
  localparam logic [1:0]  SEL_FPR   = 2'd3;
  localparam logic [15:0] FPR_RESET = 16'd49999;

  apb_state_t  apb_state;
  logic        fcr;
  logic [15:0] fdr;
  logic [3:0]  fdp;
  logic [15:0] fpr;
  logic [15:0] presc;
  logic [1:0]  idx;

  logic        access;
  logic        fpr_wr;
  logic        tick;
  logic [1:0]  reg_sel;
  logic [31:0] rd_mux;
  logic [3:0]  digit;
  logic [6:0]  seg;
  logic        blank;
  logic        unused_bits;

  assign reg_sel     = PADDR[3:2];
  // A transfer starts only from idle, so the cycle that shows PREADY
  // cannot commit a second time even though PSEL/PENABLE are still high.
  assign access      = PSEL && PENABLE && !PREADY && (apb_state == APB_IDLE);
  assign fpr_wr      = access && PWRITE && (reg_sel == SEL_FPR);
  assign tick        = fcr && (presc == fpr);
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:16]};

  // Read-back mux; unimplemented bits read as zero.
  always_comb begin
    rd_mux = 32'd0;
    case (reg_sel)
      SEL_FCR: rd_mux = {31'd0, fcr};
      SEL_FDR: rd_mux = {16'd0, fdr};
      SEL_FDP: rd_mux = {28'd0, fdp};
      SEL_FPR: rd_mux = {16'd0, fpr};
      default: rd_mux = 32'd0;
    endcase
  end

  // APB handshake FSM with register commit and registered read data.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      apb_state <= APB_IDLE;
      PREADY    <= 1'b0;
      PRDATA    <= 32'd0;
      fcr       <= 1'b0;
      fdr       <= 16'd0;
      fdp       <= 4'd0;
      fpr       <= FPR_RESET;
    end else begin
      case (apb_state)
        APB_IDLE: begin
          if (access) begin
            apb_state <= APB_ACK;
            PREADY    <= 1'b1;
            if (PWRITE) begin
              case (reg_sel)
                SEL_FCR: fcr <= PWDATA[0];
                SEL_FDR: fdr <= PWDATA[15:0];
                SEL_FDP: fdp <= PWDATA[3:0];
                SEL_FPR: fpr <= PWDATA[15:0];
                default: ;
              endcase
            end else begin
              PRDATA <= rd_mux;
            end
          end
        end
        APB_ACK: begin
          apb_state <= APB_IDLE;
          PREADY    <= 1'b0;
        end
        default: begin
          apb_state <= APB_IDLE;
          PREADY    <= 1'b0;
        end
      endcase
    end
  end

  // Prescaler and digit index; both parked at zero while disabled so that
  // re-enabling always starts a full slot on digit 0.
  always_ff @(posedge PCLK) begin
    if (PRESET || !fcr) begin
      presc <= 16'd0;
      idx   <= 2'd0;
    end else begin
      // An FPR write restarts the slot timer but leaves the digit alone;
      // a tick landing on the same edge still advances the digit.
      if (tick || fpr_wr) begin
        presc <= 16'd0;
      end else begin
        presc <= presc + 16'd1;
      end
      if (tick) begin
        idx <= idx + 2'd1;
      end
    end
  end

  // Select the nibble of the digit currently being scanned.
  always_comb begin
    digit = 4'd0;
    case (idx)
      2'd0: digit = fdr[3:0];
      2'd1: digit = fdr[7:4];
      2'd2: digit = fdr[11:8];
      2'd3: digit = fdr[15:12];
      default: digit = 4'd0;
    endcase
  end

  // Hex to active-low segment pattern (g..a).
  always_comb begin
    seg = 7'h7F;
    case (digit)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

`ifdef FND_LEADING_ZERO_BLANK_EN
  logic [1:0] msn;

  // Position of the most-significant nonzero nibble (0 when FDR is zero).
  always_comb begin
    msn = 2'd0;
    if (fdr[7:4]   != 4'd0) msn = 2'd1;
    if (fdr[11:8]  != 4'd0) msn = 2'd2;
    if (fdr[15:12] != 4'd0) msn = 2'd3;
  end

  // idx > msn implies idx > 0, so digit 0 is never blanked.
  assign blank = (idx > msn) && !fdp[idx];
`else
  assign blank = 1'b0;
`endif

  // Drive the selected digit; everything dark while disabled or blanked.
  always_comb begin
    fndcomm = 4'hF;
    fndfont = 8'hFF;
    if (fcr && !blank) begin
      fndcomm[idx] = 1'b0;
      fndfont      = {~fdp[idx], seg};
    end
  end

endmodule
